// File: rtl/j_acc_shifter_if.sv
// j_acc_shifter_if: bundles the SRAM read port, the command/status pair and
// the serial stream of the accumulator shifter.
// master = the shifter itself, slave = its environment (SRAM, controller and
// the downstream deshifter).

interface j_acc_shifter_if #(
    parameter int ADDR_W = 18
);
    // SRAM read port
    logic              sram_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_rdata;

    // Command / status
    logic              shift_start;
    logic              shift_idle;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] img_size;

    // Serial stream towards the deshifter
    logic              serial_output;
    logic              serial_en;
    logic              serial_ready;

    modport master (
        output sram_en,
        output sram_addr,
        input  sram_rdata,
        input  shift_start,
        output shift_idle,
        input  start_addr,
        input  img_size,
        output serial_output,
        output serial_en,
        input  serial_ready
    );

    modport slave (
        input  sram_en,
        input  sram_addr,
        output sram_rdata,
        output shift_start,
        input  shift_idle,
        output start_addr,
        output img_size,
        input  serial_output,
        input  serial_en,
        output serial_ready
    );
endinterface

// File: rtl/j_acc_shifter.sv
// j_acc_shifter: reads img_size+1 32-bit words from SRAM, starting at
// start_addr and stepping by 4, and serialises them one bit per accepted
// strobe. A one-word prefetch buffer refills the shift register on the same
// edge the last bit of a word leaves, so the stream has no gaps between words.
//
// Build option J_SHIFT_MSB_FIRST_EN: when defined, each word is sent MSB
// first (shift left, output bit 31). Default is LSB first (shift right,
// output bit 0), matching the deshifter's right-shift-in order.

module j_acc_shifter #(
    parameter int SRAM_DEPTH  = 256*256*4,
    parameter int SRAM_ADDR_W = $clog2(SRAM_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    j_acc_shifter_if.master  bus
);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t                 state;
    logic [SRAM_ADDR_W-1:0] img_size_q;
    logic [SRAM_ADDR_W:0]   issue_cnt;    // one extra bit so the last compare cannot wrap
    logic [SRAM_ADDR_W-1:0] sram_addr_q;
    logic                   rd_pend;

    logic [31:0]            buf_data;
    logic                   buf_valid;
    logic [31:0]            shift_reg;
    logic                   sh_valid;
    logic [4:0]             bit_cnt;

    logic                   issue;
    logic                   all_issued;
    logic                   xfer;
    logic                   word_end;
    logic                   last_xfer;
    logic [31:0]            shifted;
    logic                   ser_bit;

    // Reads are issued only into an empty, not-awaited prefetch slot.
    assign all_issued = issue_cnt > {1'b0, img_size_q};
    assign issue      = (state == S_ACTIVE) && !all_issued && !buf_valid && !rd_pend;

    assign xfer       = sh_valid & bus.serial_ready;
    assign word_end   = xfer && (bit_cnt == 5'd31);
    // Final word: everything issued and nothing left in flight or buffered.
    assign last_xfer  = word_end && all_issued && !buf_valid && !rd_pend;

`ifdef J_SHIFT_MSB_FIRST_EN
    assign shifted = {shift_reg[30:0], 1'b0};
    assign ser_bit = shift_reg[31];
`else
    assign shifted = {1'b0, shift_reg[31:1]};
    assign ser_bit = shift_reg[0];
`endif

    assign bus.sram_en       = issue;
    assign bus.sram_addr     = sram_addr_q;
    assign bus.shift_idle    = (state == S_IDLE);
    assign bus.serial_en     = xfer;
    assign bus.serial_output = ser_bit;

    // Command FSM and read issue: latch the command, walk the address, count reads.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge
        // values and the statement order inside the block does not matter.
        if (reset) begin
            state       <= S_IDLE;
            img_size_q  <= '0;
            issue_cnt   <= '0;
            sram_addr_q <= '0;
            rd_pend     <= 1'b0;
        end else begin
            // A read's data is always captured on the edge after it issued.
            rd_pend <= issue;
            case (state)
                S_IDLE: begin
                    if (bus.shift_start) begin
                        state       <= S_ACTIVE;
                        img_size_q  <= bus.img_size;
                        sram_addr_q <= bus.start_addr;
                        issue_cnt   <= '0;
                    end
                end
                S_ACTIVE: begin
                    if (issue) begin
                        issue_cnt   <= issue_cnt + 1'b1;
                        sram_addr_q <= sram_addr_q + SRAM_ADDR_W'(4);
                    end
                    if (last_xfer) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Prefetch buffer and shift register: capture read data, load/reload, shift on transfer.
    always_ff @(posedge clk) begin
        // NOTE: buf_data and shift_reg are datapath registers but are reset as
        // well, so serial_output is a defined 0 straight out of reset.
        if (reset) begin
            buf_data  <= '0;
            buf_valid <= 1'b0;
            shift_reg <= '0;
            sh_valid  <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            // rd_pend and buf_valid are never both set, so the capture below
            // cannot collide with a buffer consume.
            if (rd_pend) begin
                buf_data  <= bus.sram_rdata;
                buf_valid <= 1'b1;
            end

            if (xfer) begin
                bit_cnt <= bit_cnt + 1'b1;
                if (word_end && buf_valid) begin
                    // Seamless hand-over to the next word.
                    shift_reg <= buf_data;
                    buf_valid <= 1'b0;
                end else begin
                    shift_reg <= shifted;
                    if (word_end) begin
                        sh_valid <= 1'b0;
                    end
                end
            end else if (!sh_valid && buf_valid) begin
                shift_reg <= buf_data;
                sh_valid  <= 1'b1;
                buf_valid <= 1'b0;
            end
        end
    end

endmodule
